// File: rtl/axi_isram_rd_pkg.sv
// axi_isram_rd_pkg: shared response codes, reset PC and FSM state encodings
package axi_isram_rd_pkg;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [2:0] RESP_OKAY = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;
  localparam logic [2:0] RESP_DECERR = 3'b011;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/axi_isram_rd_if.sv
// axi_isram_rd_if: AR/R read channels plus backdoor word-load port; slave modport for the memory, master for the requester
interface axi_isram_rd_if #(parameter int DATA_LEN = 32);
  logic arvalid, arready, rvalid, rready, load_en;
  logic [DATA_LEN-1:0] araddr, rdata, load_addr, load_data;
  logic [2:0] rresp;
  modport slave (input arvalid, araddr, rready, load_en, load_addr, load_data, output arready, rdata, rvalid, rresp);
  modport master (output arvalid, araddr, rready, load_en, load_addr, load_data, input arready, rdata, rvalid, rresp);
endinterface

// File: rtl/axi_isram_rd_lfsr8.sv
// axi_isram_rd_lfsr8: 8-bit LFSR seeded 8'h01, advances only when en; ports clk, rst_n, en, q
module axi_isram_rd_lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 8'h01;
    else if (en) q <= {q[4] ^ q[3] ^ q[2] ^ q[0], q[7:1]};
endmodule

// File: rtl/axi_isram_rd.sv
// axi_isram_rd: read-only instruction SRAM slave with fixed/LFSR response latency; ports clk, rst_n, bus (AR/R channels + backdoor load)
module axi_isram_rd import axi_isram_rd_pkg::*; #(
  parameter int              DATA_LEN   = 32,
  parameter logic [31:0]     ADDR_BASE  = RESET_PC,
  parameter int              DEPTH_LOG2 = 12,
  parameter int              DELAY_MODE = 0,
  parameter logic [7:0]      FIX_DELAY  = 8'd0,
  parameter logic [7:0]      DELAY_MASK = 8'h0F
) (
  input logic             clk,
  input logic             rst_n,
  axi_isram_rd_if.slave   bus
);
  logic [DATA_LEN-1:0] mem [2**DEPTH_LOG2];
  state_t st;
  logic [7:0] cnt, lfsr;
  logic [DATA_LEN-1:0] addr_q, rd_idx, ld_idx, rdata;
  logic [2:0] rd_resp, rresp;
  logic hs, ld_ok, arready, rvalid;
  assign hs = bus.arvalid && arready;
  axi_isram_rd_lfsr8 u_lfsr (.clk(clk), .rst_n(rst_n), .en(hs), .q(lfsr));
  assign rd_idx = (addr_q - ADDR_BASE) >> 2;
  assign ld_idx = (bus.load_addr - ADDR_BASE) >> 2;
  always_comb rd_resp = addr_q[1:0] != 2'b00 ? RESP_SLVERR :
                        (addr_q < ADDR_BASE || |(rd_idx >> DEPTH_LOG2)) ? RESP_DECERR : RESP_OKAY;
  assign ld_ok = bus.load_en && bus.load_addr[1:0] == 2'b00 && bus.load_addr >= ADDR_BASE && ~|(ld_idx >> DEPTH_LOG2);
  always_ff @(posedge clk)
    if (ld_ok) mem[ld_idx[DEPTH_LOG2-1:0]] <= bus.load_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else begin
      case (st)
        IDLE: if (hs) begin
          addr_q <= bus.araddr;
          arready <= 1'b0;
          cnt <= DELAY_MODE != 0 ? (lfsr & DELAY_MASK) : FIX_DELAY;
          st <= WAIT;
        end else arready <= 1'b1;
        WAIT: if (cnt != 8'd0) cnt <= cnt - 8'd1;
        else begin
          rvalid <= 1'b1;
          rresp <= rd_resp;
          rdata <= rd_resp == RESP_OKAY ? mem[rd_idx[DEPTH_LOG2-1:0]] : '0;
          st <= RESP;
        end
        RESP: if (bus.rready) begin
          rvalid <= 1'b0;
          arready <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  assign bus.arready = arready;
  assign bus.rvalid = rvalid;
  assign bus.rdata = rdata;
  assign bus.rresp = rresp;
endmodule
